// File: rtl/link_sequencer_pkg.sv
// ============================================================================
// link_sequencer_pkg : shared state encodings, arbitration sides and
//                      watchdog defaults for the link sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package link_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_FLUSH = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  typedef enum logic {
    SIDE_WRITE = 1'b0,
    SIDE_READ  = 1'b1
  } side_e;

  localparam int DEFAULT_TIMEOUT = 4095;
  localparam int DEFAULT_TW      = 12;

  // States in which a grant is held and the watchdog must run.
  function automatic logic is_active(input state_e s);
    return (s == S_WRITE) || (s == S_READ) || (s == S_FLUSH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/link_sequencer_watchdog.sv
// ============================================================================
// link_sequencer_watchdog : clear/enable counter whose terminal-count output
//                           marks the TIMEOUT-th consecutive enabled cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module link_sequencer_watchdog
  import link_sequencer_pkg::*;
#(
  parameter int TW      = DEFAULT_TW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count holds the number of completed cycles, so TC_VAL is the last allowed one.
  assign tc = en && (count_q == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/link_sequencer.sv
// ============================================================================
// link_sequencer : round-robin arbiter granting the shared byte FIFO to the
//                  writer or reader, with error flush and watchdog abort.
// Optional macro LINK_SEQ_STATS_EN adds saturating frame/error counters.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module link_sequencer
  import link_sequencer_pkg::*;
#(
  parameter int CW      = 10,
  parameter int DEPTH   = 1023,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = DEFAULT_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic          wr_done,
  input  logic          rd_req,
  input  logic          rd_done,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [CW-1:0] fifo_count,
  input  logic [3:0]    data_error,
  output logic          wr_grant,
  output logic          rd_grant,
  output logic          flush,
  output logic          busy,
  output logic          timeout_err,
  output logic [2:0]    state_o
`ifdef LINK_SEQ_STATS_EN
  ,
  output logic [7:0]    frame_cnt,
  output logic [7:0]    err_cnt
`endif
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e state_q, state_d;
  side_e  last_q, last_d;
  logic   wr_grant_q, wr_grant_d;
  logic   rd_grant_q, rd_grant_d;
  logic   flush_q, flush_d;
  logic   busy_q, busy_d;
  logic   timeout_err_q, timeout_err_d;
  logic   wr_ok, rd_ok;
  logic   wd_clr, wd_en, wd_tc;
  logic   timeout_hit;

  assign wr_ok = wr_req && !fifo_full && (fifo_count < DEPTH_C);
  assign rd_ok = rd_req && !fifo_empty;

  assign wd_en  = is_active(state_q);
  assign wd_clr = (state_d != state_q);

  link_sequencer_watchdog #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  // Done/empty exits are tested before the watchdog so they win a tie with it.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_ok && (!rd_ok || (last_q == SIDE_READ))) begin
          state_d = S_WRITE;
        end else if (rd_ok) begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (wr_done) begin
          if (data_error == 4'd0) begin
            state_d = S_IDLE;
            last_d  = SIDE_WRITE;
          end else begin
            state_d = S_FLUSH;
          end
        end else if (wd_tc) begin
          state_d     = S_ABORT;
          timeout_hit = 1'b1;
        end
      end
      S_READ: begin
        if (rd_done) begin
          state_d = S_IDLE;
          last_d  = SIDE_READ;
        end else if (wd_tc) begin
          state_d     = S_ABORT;
          timeout_hit = 1'b1;
        end
      end
      S_FLUSH: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
          last_d  = SIDE_READ;
        end else if (wd_tc) begin
          state_d     = S_ABORT;
          timeout_hit = 1'b1;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_grant_d    = (state_d == S_WRITE);
    rd_grant_d    = (state_d == S_READ) || (state_d == S_FLUSH);
    flush_d       = (state_d == S_FLUSH);
    busy_d        = (state_d != S_IDLE);
    timeout_err_d = timeout_err_q || timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_q        <= SIDE_READ;
      wr_grant_q    <= 1'b0;
      rd_grant_q    <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      wr_grant_q    <= wr_grant_d;
      rd_grant_q    <= rd_grant_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign wr_grant    = wr_grant_q;
  assign rd_grant    = rd_grant_q;
  assign flush       = flush_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign state_o     = state_q;

  a_grant_excl: assert property (@(posedge clk) disable iff (reset) !(wr_grant_q && rd_grant_q));

`ifdef LINK_SEQ_STATS_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Only a done pulse accepted in WRITE counts as a frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if ((state_q == S_WRITE) && wr_done) begin
      if (data_error == 4'd0) begin
        if (frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  // Without statistics, wr_done and data_error feed only the state machine.
`endif

endmodule

`default_nettype wire

// File: tb/tb_link_sequencer.sv
// ============================================================================
// tb_link_sequencer : directed table-driven bench for link_sequencer, with
//                     hand sequences for watchdog, async reset and statistics.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_link_sequencer;

  // Output bundle: {wr_grant, rd_grant, flush, busy, timeout_err, state_o[2:0]}
  localparam logic [7:0] E_ID = 8'b0000_0000;
  localparam logic [7:0] E_WR = 8'b1001_0001;
  localparam logic [7:0] E_RD = 8'b0101_0010;
  localparam logic [7:0] E_FL = 8'b0111_0011;
  localparam logic [7:0] E_AB = 8'b0001_0100;
  localparam logic [7:0] TERR = 8'b0000_1000;

  logic       clk;
  logic       reset;
  logic       wr_req, wr_done, rd_req, rd_done;
  logic       fifo_empty, fifo_full;
  logic [9:0] fifo_count;
  logic [3:0] data_error;
  logic       wr_grant, rd_grant, flush, busy, timeout_err;
  logic [2:0] state_o;
`ifdef LINK_SEQ_STATS_EN
  logic [7:0] frame_cnt, err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  link_sequencer #(
    .CW      (10),
    .DEPTH   (1023),
    .TIMEOUT (16),
    .TW      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_req      (wr_req),
    .wr_done     (wr_done),
    .rd_req      (rd_req),
    .rd_done     (rd_done),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .data_error  (data_error),
    .wr_grant    (wr_grant),
    .rd_grant    (rd_grant),
    .flush       (flush),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state_o     (state_o)
`ifdef LINK_SEQ_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       wd;
    logic       rd;
    logic       rdn;
    logic       emp;
    logic       full;
    logic [9:0] cnt;
    logic [3:0] err;
    logic [7:0] expv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic wd, input logic rd, input logic rdn,
                     input logic emp, input logic full, input logic [9:0] cnt,
                     input logic [3:0] err, input logic [7:0] expv);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.rdn = rdn;
    v.emp = emp; v.full = full; v.cnt = cnt; v.err = err; v.expv = expv;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic wd, input logic rd, input logic rdn,
                       input logic emp, input logic full, input logic [9:0] cnt,
                       input logic [3:0] err);
    wr_req = wr; wr_done = wd; rd_req = rd; rd_done = rdn;
    fifo_empty = emp; fifo_full = full; fifo_count = cnt; data_error = err;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {wr_grant, rd_grant, flush, busy, timeout_err, state_o};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 10'd0, 4'd0);

    // Round-robin tie: W, R, W with a stray wr_done ignored in READ
    add(1,0,1,0, 0,0,10'd5,4'd0, E_WR);
    add(1,1,1,0, 0,0,10'd5,4'd0, E_ID);
    add(1,0,1,0, 0,0,10'd5,4'd0, E_RD);
    add(1,1,1,0, 0,0,10'd5,4'd0, E_RD);
    add(1,0,1,1, 0,0,10'd5,4'd0, E_ID);
    add(1,0,1,0, 0,0,10'd5,4'd0, E_WR);
    add(0,1,0,0, 0,0,10'd5,4'd0, E_ID);
    // Basic write, done 5 cycles after grant; full mid-burst holds the grant
    add(1,0,0,0, 1,0,10'd0,4'd0, E_WR);
    add(1,0,0,0, 1,0,10'd0,4'd0, E_WR);
    add(1,0,0,1, 1,1,10'd0,4'd0, E_WR);
    add(1,0,0,0, 1,0,10'd0,4'd0, E_WR);
    add(1,0,0,0, 1,0,10'd0,4'd0, E_WR);
    add(0,1,0,0, 1,0,10'd0,4'd0, E_ID);
    // Blocking on full flag and on DEPTH boundary, then on empty
    add(1,0,0,0, 1,1,10'd0,4'd0, E_ID);
    add(1,0,0,0, 1,1,10'd0,4'd0, E_ID);
    add(1,0,0,0, 1,0,10'd0,4'd0, E_WR);
    add(0,1,0,0, 1,0,10'd0,4'd0, E_ID);
    add(1,0,0,0, 1,0,10'd1023,4'd0, E_ID);
    add(1,0,0,0, 1,0,10'd1022,4'd0, E_WR);
    add(0,1,0,0, 1,0,10'd1022,4'd0, E_ID);
    add(0,0,1,0, 1,0,10'd0,4'd0, E_ID);
    add(0,0,1,0, 1,0,10'd0,4'd0, E_ID);
    add(0,0,1,0, 1,0,10'd0,4'd0, E_ID);
    // Error flush: wr_req and wr_done ignored until empty is sampled
    add(1,0,0,0, 0,0,10'd3,4'd0, E_WR);
    add(1,1,0,0, 0,0,10'd3,4'b0010, E_FL);
    add(1,0,0,0, 0,0,10'd3,4'd0, E_FL);
    add(1,1,0,0, 0,0,10'd2,4'b0010, E_FL);
    add(1,0,0,0, 1,0,10'd0,4'd0, E_ID);
    add(0,0,0,0, 1,0,10'd0,4'd0, E_ID);
    // Flush leaves last_served = READ, so a tie goes to the writer
    add(1,0,1,0, 0,0,10'd4,4'd0, E_WR);
    add(0,1,0,0, 0,0,10'd4,4'd0, E_ID);

    step();
    step();
    check("reset_hold", outs(), E_ID);
    reset = 1'b0;
    step();
    check("reset_idle", outs(), E_ID);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].rdn,
            vecs[i].emp, vecs[i].full, vecs[i].cnt, vecs[i].err);
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].expv);
    end

    // Watchdog: rd_done in the terminal (16th) grant cycle exits normally
    drive(0, 0, 1, 0, 0, 0, 10'd4, 4'd0);
    step();
    check("wd_done_grant", outs(), E_RD);
    rd_req = 1'b0;
    for (int i = 1; i <= 15; i++) step();
    check("wd_done_cycle16", outs(), E_RD);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("wd_done_exit", outs(), E_ID);
    step();
    check("wd_done_noerr", outs(), E_ID);

    // Watchdog: no done, one ABORT cycle after 16 grant cycles, sticky error
    rd_req = 1'b1;
    step();
    check("wd_to_grant", outs(), E_RD);
    rd_req = 1'b0;
    for (int i = 1; i <= 15; i++) step();
    check("wd_to_last_grant", outs(), E_RD);
    step();
    check("wd_to_abort", outs(), E_AB | TERR);
    step();
    check("wd_to_idle", outs(), E_ID | TERR);
    step();
    step();
    step();
    check("wd_to_sticky", outs(), E_ID | TERR);

    // Asynchronous reset in WRITE drops everything before the next edge
    drive(1, 0, 0, 0, 1, 0, 10'd0, 4'd0);
    step();
    check("arst_write", outs(), E_WR | TERR);
    #3;
    reset = 1'b1;
    #1;
    check("arst_immediate", outs(), E_ID);
    wr_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("arst_after", outs(), E_ID);

`ifdef LINK_SEQ_STATS_EN
    for (int i = 0; i < 300; i++) begin
      wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
    end
    check("stats_frame_sat", frame_cnt, 8'hFF);
    check("stats_err_zero", err_cnt, 8'h00);
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    wr_done = 1'b1;
    data_error = 4'b0100;
    fifo_empty = 1'b0;
    step();
    wr_done = 1'b0;
    data_error = 4'd0;
    fifo_empty = 1'b1;
    step();
    check("stats_err_one", err_cnt, 8'h01);
    check("stats_frame_hold", frame_cnt, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/link_sequencer.md
Name: link_sequencer

Overview:
- Controls the shared byte FIFO between the parallel-input writer (Between_to_FIFO path) and the UART-output reader (FIFO_to_out/Out_to_com path).
- Replaces the constant-1 enables with registered, mutually exclusive grants.
- Arbitrates write and read bursts with round-robin fairness, blocks on full/empty, and aborts hung bursts with a watchdog.
- Drains the FIFO when a frame arrives with a nonzero error syndrome.

Parameters:
- CW, 10, width of the FIFO occupancy count input.
- DEPTH, 1023, occupancy at which the FIFO is treated as full (checked together with the fifo_full input).
- TIMEOUT, 4095, maximum number of cycles a grant may stay high without its done pulse.
- TW, 12, watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  sequencer clock (same domain as FIFO).
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  1  writer has a byte/frame pending.
- wr_done  in  1  one-cycle pulse: writer burst complete.
- rd_req  in  1  reader ready to send.
- rd_done  in  1  one-cycle pulse: reader burst complete.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_count  in  CW  FIFO occupancy.
- data_error  in  4  writer error syndrome, valid with wr_done.
- wr_grant  out  1  enable to writer.
- rd_grant  out  1  enable to reader.
- flush  out  1  drain request; forces reader enable, suppresses writer.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on watchdog abort; cleared only by reset.
- state_o  out  3  current state encoding, for debug and the seven-segment display.

Behaviour:
- Reset: all outputs 0, state IDLE, watchdog 0, last_served = READ (so the writer wins the first tie).
- All outputs are registered. A grant rises one cycle after the request is sampled in IDLE and falls in the cycle after done is sampled.
- States: IDLE=0, WRITE=1, READ=2, FLUSH=3, ABORT=4.
- Eligibility:
  - wr_ok = wr_req & !fifo_full & (fifo_count < DEPTH).
  - rd_ok = rd_req & !fifo_empty.
- IDLE:
  - Only wr_ok → WRITE.
  - Only rd_ok → READ.
  - Both → the side opposite last_served.
  - Neither → stay in IDLE.
- WRITE:
  - wr_grant = 1.
  - On wr_done with data_error == 0 → IDLE, last_served = WRITE.
  - On wr_done with data_error != 0 → FLUSH.
  - If fifo_full rises before done, hold the grant; the writer stalls via the FIFO busy/full signals.
- READ:
  - rd_grant = 1.
  - On rd_done → IDLE, last_served = READ.
- FLUSH:
  - flush = 1 and rd_grant = 1; wr_grant = 0.
  - Stay until fifo_empty is sampled high, then → IDLE with last_served = READ.
  - wr_req is ignored throughout.
- ABORT:
  - All grants 0 for exactly one cycle, then → IDLE.
- Watchdog:
  - Clears on every state entry.
  - Increments each cycle in WRITE, READ or FLUSH.
  - Reaching TIMEOUT → ABORT and set timeout_err.
  - A done pulse in the same cycle as the timeout wins: normal transition, no error.
- Done pulses received in a state that does not expect them are ignored.
- wr_grant and rd_grant are never both 1. Assert this as an invariant.
- Asynchronous reset mid-burst: grants drop immediately, without waiting for the clock.

Optional Feature:
- Macro: LINK_SEQ_STATS_EN.
- Defined:
  - Adds outputs frame_cnt[7:0] (incremented on each clean wr_done) and err_cnt[7:0] (incremented on each wr_done with nonzero data_error).
  - Both counters saturate at 8'hFF and reset to 0.
- Undefined: these ports do not exist; no counter logic is present.

Decomposition:
- Shared package/header `include "../module/link_seq_defs.v":
  - state encodings S_IDLE..S_ABORT;
  - default TIMEOUT;
  - the SIDE_WRITE/SIDE_READ constants for last_served.
- One natural sub-module, link_watchdog: a clear/enable/terminal-count counter parameterized by TW and TIMEOUT.

Test Plan:
- Basic write:
  - Stimulus: reset, then wr_req=1 with FIFO non-full, then wr_done 5 cycles after the grant.
  - Required: wr_grant rises 1 cycle after wr_req; falls 1 cycle after done; state_o returns to 0.
- Tie and round-robin:
  - Stimulus: wr_req and rd_req both high after reset, fifo_empty=0.
  - Required: grant order is WRITE, READ, WRITE over three bursts.
- Blocking:
  - Stimulus: fifo_full=1 with only wr_req.
  - Required: stays IDLE with no grant; clearing fifo_full grants the write next cycle.
  - Stimulus: fifo_empty=1 with only rd_req.
  - Required: never grants.
- Error flush:
  - Stimulus: wr_done with data_error=4'b0010, fifo_count=3.
  - Required: flush=1 and rd_grant=1; wr_req is ignored; return to IDLE the cycle after fifo_empty is sampled high.
- Watchdog:
  - Stimulus: TIMEOUT=16, grant READ, never pulse rd_done.
  - Required: after 16 cycles, one ABORT cycle with both grants 0; timeout_err=1 and stays set.
  - Stimulus: rd_done in the terminal cycle.
  - Required: normal exit, timeout_err stays 0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously in WRITE.
  - Required: wr_grant drops before the next clk edge; all outputs 0.
  - With LINK_SEQ_STATS_EN: after 300 clean frames, frame_cnt=8'hFF.
